// File: rtl/bist_addr_cmp.sv
// -----------------------------------------------------------------------------
// bist_addr_cmp
// Memory BIST datapath stage. It holds the up/down address counter that the
// BIST control FSM steers through the March elements. It drives the array
// address, the read/write strobes and the background data. Returning read data
// is aligned with the expected word through an RD_LAT-deep compare pipeline,
// which produces is_equal and a sticky failure log
// (err_flag / err_addr / err_count).
// -----------------------------------------------------------------------------
module bist_addr_cmp #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1   // memory read latency, legal 1..4
) (
  input  logic              clk,
  input  logic              rst,        // asynchronous, active-low
  input  logic              start,
  input  logic              cnt_reset,
  input  logic              cnt_preset,
  input  logic              en,
  input  logic              up_down,
  input  logic              read,
  input  logic              write,
  input  logic              data,
  output logic              carry,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_re,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              is_equal,
  output logic              err_flag,
  output logic [ADDR_W-1:0] err_addr,
  output logic [7:0]        err_count
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [7:0]        CNT_SAT  = 8'hFF;

  // ---------------------------------------------------------------------------
  // Address counter
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  // Next counter value: reset beats preset beats step; wraps modulo 2^ADDR_W.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the block leaves it unassigned and infers a latch.
    cnt_d = cnt_q;
    if (cnt_reset) begin
      cnt_d = '0;
    end else if (cnt_preset) begin
      cnt_d = ADDR_MAX;
    end else if (en) begin
      cnt_d = up_down ? (cnt_q + ADDR_ONE) : (cnt_q - ADDR_ONE);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement or block ordering.
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Terminal count marks the last access of the current element.
  assign carry = en & (up_down ? (cnt_q == ADDR_MAX) : (cnt_q == '0));

  // ---------------------------------------------------------------------------
  // Memory interface. read & write together is illegal: both strobes drop.
  // ---------------------------------------------------------------------------
  assign mem_addr  = cnt_q;
  assign mem_we    = en & write & ~read;
  assign mem_re    = en & read & ~write;
  assign mem_wdata = {DATA_W{data}};

  // ---------------------------------------------------------------------------
  // Compare pipeline: one stage per cycle of read latency; the last stage is
  // the compare point that lines up with mem_rdata.
  // ---------------------------------------------------------------------------
  logic              vld_q [RD_LAT];
  logic [DATA_W-1:0] exp_q [RD_LAT];
  logic [ADDR_W-1:0] adr_q [RD_LAT];

  // Valid bits: these are the only pipeline state that must be reset, so an
  // in-flight compare is discarded when reset is asserted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RD_LAT; i++) vld_q[i] <= 1'b0;
    end else begin
      vld_q[0] <= mem_re;
      for (int i = 1; i < RD_LAT; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  // Expected word and address payload travelling alongside the valid bit.
  always_ff @(posedge clk) begin
    // NOTE: payload storage is deliberately not reset; it is only observed
    // when the matching valid bit is set, and leaving it unreset keeps these
    // flops free of reset routing.
    exp_q[0] <= mem_wdata;
    adr_q[0] <= mem_addr;
    for (int i = 1; i < RD_LAT; i++) begin
      exp_q[i] <= exp_q[i-1];
      adr_q[i] <= adr_q[i-1];
    end
  end

  logic              cmp_valid;
  logic [DATA_W-1:0] cmp_expected;
  logic [ADDR_W-1:0] cmp_addr;
  logic              cmp_fail;

  assign cmp_valid    = vld_q[RD_LAT-1];
  assign cmp_expected = exp_q[RD_LAT-1];
  assign cmp_addr     = adr_q[RD_LAT-1];
  assign is_equal     = ~cmp_valid | (mem_rdata == cmp_expected);
  assign cmp_fail     = ~is_equal;

  // ---------------------------------------------------------------------------
  // Failure log
  // ---------------------------------------------------------------------------
  logic              err_flag_q, err_flag_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic [7:0]        err_count_q, err_count_d;

  // Next log state: a start pulse clears first, then a mismatch in the same
  // cycle is recorded on top of the cleared log.
  always_comb begin
    err_flag_d  = err_flag_q;
    err_addr_d  = err_addr_q;
    err_count_d = err_count_q;
    if (start) begin
      err_flag_d  = 1'b0;
      err_addr_d  = '0;
      err_count_d = '0;
    end
    if (cmp_fail) begin
      if (!err_flag_d) err_addr_d = cmp_addr;
      err_flag_d = 1'b1;
      if (err_count_d != CNT_SAT) err_count_d = err_count_d + 8'd1;
    end
  end

  // Log registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_flag_q  <= 1'b0;
      err_addr_q  <= '0;
      err_count_q <= '0;
    end else begin
      err_flag_q  <= err_flag_d;
      err_addr_q  <= err_addr_d;
      err_count_q <= err_count_d;
    end
  end

  assign err_flag  = err_flag_q;
  assign err_addr  = err_addr_q;
  assign err_count = err_count_q;

endmodule
